// File: rtl/md_pad_pkg.sv
// Shared types and constants for the Mega Drive pad scanner.
package md_pad_pkg;

    // Scanner sequence: pad 1, pad 2, then a long idle so 6-button pads
    // drop back to their base state.
    typedef enum logic [1:0] {
        SCAN1 = 2'd0,
        SCAN2 = 2'd1,
        IDLE  = 2'd2
    } state_t;

    // Bit positions in the active-high button word.
    localparam int BTN_R     = 0;
    localparam int BTN_L     = 1;
    localparam int BTN_D     = 2;
    localparam int BTN_U     = 3;
    localparam int BTN_B     = 4;
    localparam int BTN_C     = 5;
    localparam int BTN_A     = 6;
    localparam int BTN_START = 7;
    localparam int BTN_MODE  = 8;
    localparam int BTN_X     = 9;
    localparam int BTN_Y     = 10;
    localparam int BTN_Z     = 11;

    // Select phases that matter within one 8-phase scan.
    localparam logic [2:0] PH_BASE = 3'd0;
    localparam logic [2:0] PH_AB   = 3'd1;
    localparam logic [2:0] PH_DET  = 3'd5;
    localparam logic [2:0] PH_XYZ  = 3'd6;
    localparam logic [2:0] PH_LAST = 3'd7;

    // Final word for one pad: absent pads read as all-zero, and the
    // extended buttons only survive when the pad identified as 6-button.
    function automatic logic [15:0] commit_word(input logic        present,
                                                input logic        six,
                                                input logic [11:0] shadow);
        logic [15:0] w;
        w = '0;
        if (present) begin
            w[7:0] = shadow[7:0];
            if (six) begin
                w[11:8] = shadow[11:8];
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/md_tick_gen.sv
// Phase-rate tick generator: one-cycle pulse every TICK_DIV clocks.
module md_tick_gen #(
    parameter int TICK_DIV = 400
) (
    input  logic i_clk,
    input  logic i_rst_n,
    output logic o_tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] r_cnt;
    logic          w_last;

    assign w_last = (r_cnt == CW'(TICK_DIV - 1));
    assign o_tick = w_last;

    // Free-running divider, wraps to zero in the tick cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (w_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/md_pad_scanner.sv
// Scans two Mega Drive 3/6-button pads through the shared split/select
// lines and publishes one atomically committed button word per pad.
//
// Pad pins (joy_in) are active-low and read through a 2-flop synchronizer.
// joy_mdsel / joy_split are registered and only move in a tick cycle, so the
// pad lines have a full phase minus the synchronizer delay to settle before
// the next sample.
module md_pad_scanner
    import md_pad_pkg::*;
#(
    parameter int TICK_DIV   = 400,
    parameter int IDLE_TICKS = 160
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [5:0]  joy_in,
    output logic        joy_mdsel,
    output logic        joy_split,
    output logic [15:0] joystick1,
    output logic [15:0] joystick2,
    output logic [1:0]  pad_present,
    output logic [1:0]  pad_six,
    output logic        scan_done,
    output logic [1:0]  o_dbg_state
);

    localparam int IW = $clog2(IDLE_TICKS);

    logic          w_tick;
    logic [5:0]    r_sync1;
    logic [5:0]    r_sync2;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [2:0]    r_phase;
    logic [2:0]    w_phase_nxt;
    logic [IW-1:0] r_idle_cnt;
    logic [IW-1:0] w_idle_nxt;
    logic          w_commit;
    logic          w_mdsel_nxt;
    logic          w_split_nxt;
    logic          r_mdsel;
    logic          r_split;

    logic [11:0]   r_shadow;
    logic          r_sh_present;
    logic          r_sh_six;

    logic [15:0]   r_joy1;
    logic [15:0]   r_joy2;
    logic [1:0]    r_present;
    logic [1:0]    r_six;
    logic          r_scan_done;

    md_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .i_clk   (clk),
        .i_rst_n (reset_n),
        .o_tick  (w_tick)
    );

    // Two-flop synchronizer for the asynchronous pad lines (idle high).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= 6'h3F;
            r_sync2 <= 6'h3F;
        end else begin
            r_sync1 <= joy_in;
            r_sync2 <= r_sync1;
        end
    end

    // Sequencer state, phase counters and registered pad select lines.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= SCAN1;
            r_phase    <= PH_BASE;
            r_idle_cnt <= '0;
            r_mdsel    <= 1'b1;
            r_split    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_phase    <= w_phase_nxt;
            r_idle_cnt <= w_idle_nxt;
            r_mdsel    <= w_mdsel_nxt;
            r_split    <= w_split_nxt;
        end
    end

    // Next-state logic; every advance waits for the phase tick.
    always_comb begin
        w_state_nxt = r_state;
        w_phase_nxt = r_phase;
        w_idle_nxt  = r_idle_cnt;
        w_commit    = 1'b0;
        if (w_tick) begin
            case (r_state)
                SCAN1: begin
                    if (r_phase == PH_LAST) begin
                        w_state_nxt = SCAN2;
                        w_phase_nxt = PH_BASE;
                        w_commit    = 1'b1;
                    end else begin
                        w_phase_nxt = r_phase + 3'd1;
                    end
                end
                SCAN2: begin
                    if (r_phase == PH_LAST) begin
                        w_state_nxt = IDLE;
                        w_phase_nxt = PH_BASE;
                        w_idle_nxt  = '0;
                        w_commit    = 1'b1;
                    end else begin
                        w_phase_nxt = r_phase + 3'd1;
                    end
                end
                IDLE: begin
                    if (r_idle_cnt == IW'(IDLE_TICKS - 1)) begin
                        w_state_nxt = SCAN1;
                        w_phase_nxt = PH_BASE;
                        w_idle_nxt  = '0;
                    end else begin
                        w_idle_nxt = r_idle_cnt + IW'(1);
                    end
                end
                default: begin
                    w_state_nxt = SCAN1;
                    w_phase_nxt = PH_BASE;
                    w_idle_nxt  = '0;
                end
            endcase
        end
        // Select is high on even phases and throughout idle.
        w_mdsel_nxt = (w_state_nxt == IDLE) ? 1'b1 : ~w_phase_nxt[0];
        w_split_nxt = (w_state_nxt != SCAN1);
    end

    // Shadow capture at the end of each sampling phase of a scan.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_shadow     <= '0;
            r_sh_present <= 1'b0;
            r_sh_six     <= 1'b0;
        end else if (w_tick && (r_state != IDLE)) begin
            case (r_phase)
                PH_BASE: begin
                    r_shadow         <= '0;
                    r_shadow[BTN_U]  <= ~r_sync2[0];
                    r_shadow[BTN_D]  <= ~r_sync2[1];
                    r_shadow[BTN_L]  <= ~r_sync2[2];
                    r_shadow[BTN_R]  <= ~r_sync2[3];
                    r_shadow[BTN_B]  <= ~r_sync2[4];
                    r_shadow[BTN_C]  <= ~r_sync2[5];
                    r_sh_present     <= 1'b0;
                    r_sh_six         <= 1'b0;
                end
                PH_AB: begin
                    r_shadow[BTN_A]     <= ~r_sync2[4];
                    r_shadow[BTN_START] <= ~r_sync2[5];
                    // A connected pad grounds Left/Right while select is low.
                    r_sh_present        <= (r_sync2[3:2] == 2'b00);
                end
                PH_DET: begin
                    // A 6-button pad grounds all four direction lines here.
                    r_sh_six <= (r_sync2[3:0] == 4'b0000);
                end
                PH_XYZ: begin
                    if (r_sh_six) begin
                        r_shadow[BTN_Z]    <= ~r_sync2[0];
                        r_shadow[BTN_Y]    <= ~r_sync2[1];
                        r_shadow[BTN_X]    <= ~r_sync2[2];
                        r_shadow[BTN_MODE] <= ~r_sync2[3];
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Commit the finished shadow to the selected pad's outputs in one cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_joy1      <= '0;
            r_joy2      <= '0;
            r_present   <= '0;
            r_six       <= '0;
            r_scan_done <= 1'b0;
        end else begin
            r_scan_done <= w_commit && (r_state == SCAN2);
            if (w_commit) begin
                if (r_state == SCAN1) begin
                    r_joy1       <= commit_word(r_sh_present, r_sh_six, r_shadow);
                    r_present[0] <= r_sh_present;
                    r_six[0]     <= r_sh_present & r_sh_six;
                end else begin
                    r_joy2       <= commit_word(r_sh_present, r_sh_six, r_shadow);
                    r_present[1] <= r_sh_present;
                    r_six[1]     <= r_sh_present & r_sh_six;
                end
            end
        end
    end

    assign joy_mdsel   = r_mdsel;
    assign joy_split   = r_split;
    assign joystick1   = r_joy1;
    assign joystick2   = r_joy2;
    assign pad_present = r_present;
    assign pad_six     = r_six;
    assign scan_done   = r_scan_done;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_md_pad_scanner.sv
// Bench for md_pad_scanner: behavioural 3/6-button pad models on the
// split/select lines, expected frames queued when pads are configured and
// checked when scan_done fires.
module tb_md_pad_scanner;
  import md_pad_pkg::*;

  localparam int T     = 8;
  localparam int IDLE  = 150;
  localparam int FRAME = (16 + IDLE) * T;
  localparam int W     = 36;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [5:0]  joy_in;
  logic        joy_mdsel;
  logic        joy_split;
  logic [15:0] joystick1;
  logic [15:0] joystick2;
  logic [1:0]  pad_present;
  logic [1:0]  pad_six;
  logic        scan_done;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q[$];

  // pad configuration (buttons active-high, bit layout of the output word)
  logic        p1_pres = 1'b0;
  logic        p1_six = 1'b0;
  logic [11:0] p1_btn = '0;
  logic        p2_pres = 1'b0;
  logic        p2_six = 1'b0;
  logic [11:0] p2_btn = '0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  md_pad_scanner #(
    .TICK_DIV   (T),
    .IDLE_TICKS (IDLE)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .joy_in      (joy_in),
    .joy_mdsel   (joy_mdsel),
    .joy_split   (joy_split),
    .joystick1   (joystick1),
    .joystick2   (joystick2),
    .pad_present (pad_present),
    .pad_six     (pad_six),
    .scan_done   (scan_done),
    .o_dbg_state (dbg_state)
  );

  // ---------------- pad models ----------------
  // Each pad counts select falling edges while it is the selected pad; the
  // count restarts whenever the split line moves.
  int   c1 = 0;
  int   c2 = 0;
  logic prev_split = 1'b0;
  logic prev_mdsel = 1'b1;

  always @(posedge clk) begin
    if (joy_split !== prev_split) begin
      c1 <= 0;
      c2 <= 0;
    end else if (prev_mdsel === 1'b1 && joy_mdsel === 1'b0) begin
      if (joy_split) c2 <= c2 + 1;
      else           c1 <= c1 + 1;
    end
    prev_split <= joy_split;
    prev_mdsel <= joy_mdsel;
  end

  function automatic logic [5:0] pad_lines(input logic pres, input logic six,
                                           input logic [11:0] b, input logic sel,
                                           input int cnt);
    logic [5:0] v;
    if (!pres) return 6'h3F;
    if (sel) begin
      if (six && cnt == 3) v[3:0] = ~{b[8], b[9], b[10], b[11]};
      else                 v[3:0] = ~{b[0], b[1], b[2], b[3]};
      v[5:4] = ~{b[5], b[4]};
    end else begin
      if (six && cnt == 3) v[3:0] = 4'b0000;
      else                 v[3:0] = {2'b00, ~b[2], ~b[3]};
      v[5:4] = ~{b[7], b[6]};
    end
    return v;
  endfunction

  assign joy_in = joy_split ? pad_lines(p2_pres, p2_six, p2_btn, joy_mdsel, c2)
                            : pad_lines(p1_pres, p1_six, p1_btn, joy_mdsel, c1);

  // ---------------- scoreboard ----------------
  function automatic logic [15:0] exp_word(input logic pres, input logic six,
                                           input logic [11:0] b);
    if (!pres) return 16'h0000;
    if (six)   return {4'h0, b};
    return {8'h00, b[7:0]};
  endfunction

  task automatic push_frame();
    exp_q.push_back({exp_word(p1_pres, p1_six, p1_btn),
                     exp_word(p2_pres, p2_six, p2_btn),
                     p2_pres, p1_pres,
                     p2_pres & p2_six, p1_pres & p1_six});
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic fail_now(input string tag);
    checks++;
    errors++;
    $error("FAIL %s observed=timeout expected=event", tag);
  endtask

  task automatic compare_frame(input string tag);
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      fail_now({tag, "_queue_empty"});
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_joy1"},    joystick1, e[35:20]);
      chk({tag, "_joy2"},    joystick2, e[19:4]);
      chk({tag, "_present"}, {14'b0, pad_present}, {14'b0, e[3:2]});
      chk({tag, "_six"},     {14'b0, pad_six},     {14'b0, e[1:0]});
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_done(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (scan_done !== 1'b1 && n < 2 * FRAME);
    if (scan_done !== 1'b1) begin
      fail_now({tag, "_scan_done"});
      if (exp_q.size() != 0) void'(exp_q.pop_front());
    end else begin
      compare_frame(tag);
    end
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    // reset values while held in reset
    wait_neg(3);
    chk("rst_mdsel", {15'b0, joy_mdsel}, 16'd1);
    chk("rst_split", {15'b0, joy_split}, 16'd0);
    chk("rst_joy1", joystick1, 16'h0000);
    chk("rst_joy2", joystick2, 16'h0000);
    chk("rst_present", {14'b0, pad_present}, 16'd0);
    chk("rst_six", {14'b0, pad_six}, 16'd0);
    chk("rst_done", {15'b0, scan_done}, 16'd0);
    chk("rst_state", {14'b0, dbg_state}, {14'b0, SCAN1});
    reset_n = 1'b1;

    // frame 1: both pads absent, select timing
    push_frame();
    chk("ph0_mdsel", {15'b0, joy_mdsel}, 16'd1);
    chk("ph0_split", {15'b0, joy_split}, 16'd0);
    for (int p = 1; p < 16; p++) begin
      wait_neg(T);
      chk($sformatf("ph%0d_mdsel", p), {15'b0, joy_mdsel}, {15'b0, ~p[0]});
      chk($sformatf("ph%0d_split", p), {15'b0, joy_split}, {15'b0, (p >= 8)});
      chk($sformatf("ph%0d_done", p), {15'b0, scan_done}, 16'd0);
    end
    wait_neg(T);
    chk("f1_done", {15'b0, scan_done}, 16'd1);
    chk("idle_mdsel", {15'b0, joy_mdsel}, 16'd1);
    chk("idle_split", {15'b0, joy_split}, 16'd1);
    compare_frame("absent");

    // frame 2 configured during idle: 3-button pad 1, Right + A
    p1_pres = 1'b1;
    p1_six  = 1'b0;
    p1_btn  = 12'h041;
    push_frame();

    wait_neg(1);
    chk("done_pulse_width", {15'b0, scan_done}, 16'd0);
    wait_neg(IDLE * T - 2);
    chk("idle_end_mdsel", {15'b0, joy_mdsel}, 16'd1);
    chk("idle_end_split", {15'b0, joy_split}, 16'd1);
    wait_neg(1);
    chk("restart_split", {15'b0, joy_split}, 16'd0);
    chk("restart_mdsel", {15'b0, joy_mdsel}, 16'd1);
    wait_neg(T);
    chk("restart_ph1_mdsel", {15'b0, joy_mdsel}, 16'd0);
    wait_done("pad1_3btn");

    // frame 3: 6-button pad 2, Start + X + Z
    p2_pres = 1'b1;
    p2_six  = 1'b1;
    p2_btn  = 12'hA80;
    push_frame();
    wait_done("pad2_6btn");

    // frame 4: 6-button pad 1 (U, C, Mode, Y), 3-button pad 2 (L, D, B, Start)
    p1_pres = 1'b1; p1_six = 1'b1; p1_btn = 12'h528;
    p2_pres = 1'b1; p2_six = 1'b0; p2_btn = 12'h096;
    push_frame();
    wait_done("mixed");

    // frames 5-7: random pads
    for (int i = 0; i < 3; i++) begin
      p1_pres = ($urandom_range(0, 3) != 0);
      p1_six  = $urandom_range(0, 1) == 1;
      p1_btn  = 12'($urandom_range(0, 4095));
      if (!p1_six && p1_btn[3] && p1_btn[2]) p1_btn[2] = 1'b0;
      p2_pres = ($urandom_range(0, 3) != 0);
      p2_six  = $urandom_range(0, 1) == 1;
      p2_btn  = 12'($urandom_range(0, 4095));
      if (!p2_six && p2_btn[3] && p2_btn[2]) p2_btn[2] = 1'b0;
      push_frame();
      wait_done($sformatf("rand%0d", i));
    end

    // button change mid-scan: B pressed during pad 1 phase 3
    p1_pres = 1'b1; p1_six = 1'b0; p1_btn = 12'h001;
    p2_pres = 1'b0; p2_six = 1'b0; p2_btn = 12'h000;
    push_frame();
    wait_neg(153 * T + T / 2);
    chk("midscan_state", {14'b0, dbg_state}, {14'b0, SCAN1});
    p1_btn = 12'h011;
    push_frame();
    wait_done("b_late");
    chk("b_late_bit4", {15'b0, joystick1[4]}, 16'd0);
    wait_done("b_next");

    // reset during SCAN2 phase 4, then first commit after 8 phases
    wait_neg(162 * T + T / 2);
    chk("pre_rst_state", {14'b0, dbg_state}, {14'b0, SCAN2});
    chk("pre_rst_joy1", joystick1, 16'h0011);
    #1;
    reset_n = 1'b0;
    #1;
    chk("async_mdsel", {15'b0, joy_mdsel}, 16'd1);
    chk("async_split", {15'b0, joy_split}, 16'd0);
    chk("async_joy1", joystick1, 16'h0000);
    chk("async_joy2", joystick2, 16'h0000);
    chk("async_present", {14'b0, pad_present}, 16'd0);
    chk("async_six", {14'b0, pad_six}, 16'd0);
    chk("async_state", {14'b0, dbg_state}, {14'b0, SCAN1});
    wait_neg(2);
    reset_n = 1'b1;
    push_frame();
    wait_neg(8 * T - 1);
    chk("post_rst_early_joy1", joystick1, 16'h0000);
    chk("post_rst_early_present", {14'b0, pad_present}, 16'd0);
    wait_neg(1);
    begin
      logic [W-1:0] e;
      e = exp_q.pop_front();
      chk("post_rst_joy1", joystick1, e[35:20]);
      chk("post_rst_present", {14'b0, pad_present}, {14'b0, e[3:2]});
      chk("post_rst_joy2", joystick2, 16'h0000);
    end
    chk("post_rst_state", {14'b0, dbg_state}, {14'b0, SCAN2});
    chk("post_rst_done", {15'b0, scan_done}, 16'd0);

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
